// File: rtl/store_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// store_conditioner_pkg
// Shared definitions for the switch-addressed memory lab: debounce FSM state
// encodings, the default debounce length, and the data/address widths that the
// memory stage also uses.
// -----------------------------------------------------------------------------
package store_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    // 10 ms at 100 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;

endpackage

// File: rtl/store_conditioner_sync.sv
// -----------------------------------------------------------------------------
// sync_chain
// Plain flop chain used to bring asynchronous inputs into the clk domain.
// Every stage resets to zero synchronously.
//
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   d_i    - asynchronous input vector (WIDTH bits)
//   q_o    - synchronised output, DEPTH cycles later
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    // Stage 0 takes the raw input; each later stage takes its predecessor.
    assign stage_d[0] = d_i;

    generate
        for (genvar gi = 1; gi < int'(DEPTH); gi++) begin : g_stage
            assign stage_d[gi] = stage_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/store_conditioner.sv
// -----------------------------------------------------------------------------
// store_conditioner
// Input stage for the 4-byte switch-addressed memory. Synchronises the store
// button and the data/address switches, debounces the button, and issues one
// single-cycle store strobe per physical press with data/addr frozen at that
// strobe. A 4-bit wrapping count of issued strobes drives the LEDs.
//
// Ports:
//   clk          - system clock
//   reset        - synchronous, active-high reset (highest priority)
//   btn_store    - raw, bouncy push-button
//   sw_data[7:0] - raw data switches
//   sw_addr[1:0] - raw address switches
//   store        - one-cycle write strobe to the memory stage
//   data[7:0]    - captured data byte, valid with and held after store
//   addr[1:0]    - captured address, valid with and held after store
//   write_count  - number of strobes issued, modulo 16
// -----------------------------------------------------------------------------
module store_conditioner
    import store_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_store,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [ADDR_W-1:0] sw_addr,
    output logic              store,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr,
    output logic [3:0]        write_count
);

    // Counter only ever needs to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned      CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ---------------------------------------------------------------- sync
    logic                     btn_s;
    logic [DATA_W+ADDR_W-1:0] sw_s;

    sync_chain #(
        .WIDTH (1),
        .DEPTH (SYNC_STAGES)
    ) u_sync_btn (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_store),
        .q_o   (btn_s)
    );

    sync_chain #(
        .WIDTH (DATA_W + ADDR_W),
        .DEPTH (SYNC_STAGES)
    ) u_sync_sw (
        .clk   (clk),
        .reset (reset),
        .d_i   ({sw_addr, sw_data}),
        .q_o   (sw_s)
    );

    // ---------------------------------------------------------------- state
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              store_q, store_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        write_count_q, write_count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            store_q       <= 1'b0;
            data_q        <= '0;
            addr_q        <= '0;
            write_count_q <= 4'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            store_q       <= store_d;
            data_q        <= data_d;
            addr_q        <= addr_d;
            write_count_q <= write_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        store_d       = 1'b0;
        data_d        = data_q;
        addr_d        = addr_q;
        write_count_d = write_count_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                end
            end

            PRESS_WAIT: begin
                if (!btn_s) begin
                    // Any low sample restarts qualification from scratch.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    // Press qualified: capture switches and fire the strobe.
                    state_d       = HELD;
                    store_d       = 1'b1;
                    data_d        = sw_s[DATA_W-1:0];
                    addr_d        = sw_s[DATA_W+ADDR_W-1:DATA_W];
                    write_count_d = write_count_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end

            RELEASE_WAIT: begin
                if (btn_s) begin
                    // Release bounce: still considered held, no new strobe.
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign store       = store_q;
    assign data        = data_q;
    assign addr        = addr_q;
    assign write_count = write_count_q;

endmodule
